// File: rtl/mpu_mult_sequencer.sv
// mpu_mult_sequencer
// Sequences one matrix multiply C = A x B through a shared scalar FPU.
// Operands come from the matrix register file (1-cycle read latency); every
// product and every accumulation is issued as a single FPU request with a
// req/ack handshake; each finished dot product is written back to dst.
//
// Optional feature macro: MPU_SEQ_FUSED_FIRST_EN
//   defined   : the first product of each dot product (kk == 0) is loaded
//               straight into the accumulator and its ADD is skipped.
//   undefined : every product is added to an accumulator that starts at +0.0.
//
// dst may alias src_a/src_b; there is no hazard protection, results are
// written in the order they are computed.
module mpu_mult_sequencer #(
  parameter int FP = 32,
  parameter int M  = 2,
  parameter int K  = 2,
  parameter int N  = 2,
  parameter int RW = 2,
  parameter int IW = 1,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [RW-1:0] src_a,
  input  logic [RW-1:0] src_b,
  input  logic [RW-1:0] dst,
  input  logic [DW-1:0] dim_m,
  input  logic [DW-1:0] dim_k,
  input  logic [DW-1:0] dim_n,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          rd_en,
  output logic [RW-1:0] rd_a_reg,
  output logic [RW-1:0] rd_b_reg,
  output logic [IW-1:0] rd_a_row,
  output logic [IW-1:0] rd_a_col,
  output logic [IW-1:0] rd_b_row,
  output logic [IW-1:0] rd_b_col,
  input  logic [FP-1:0] rd_a_data,
  input  logic [FP-1:0] rd_b_data,
  output logic          fpu_req,
  output logic [1:0]    fpu_op,
  output logic [FP-1:0] fpu_a,
  output logic [FP-1:0] fpu_b,
  input  logic          fpu_ack,
  input  logic [FP-1:0] fpu_result,
  input  logic          fpu_result_valid,
  output logic          wr_en,
  output logic [RW-1:0] wr_reg,
  output logic [IW-1:0] wr_row,
  output logic [IW-1:0] wr_col,
  output logic [FP-1:0] wr_data
);

  // fpu_operation_t encoding
  localparam logic [1:0] FPU_NOP  = 2'd0;
  localparam logic [1:0] FPU_ADD  = 2'd1;
  localparam logic [1:0] FPU_MULT = 2'd2;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CHECK    = 4'd1;
  localparam logic [3:0] S_READ     = 4'd2;
  localparam logic [3:0] S_RDWAIT   = 4'd3;
  localparam logic [3:0] S_MUL_REQ  = 4'd4;
  localparam logic [3:0] S_MUL_WAIT = 4'd5;
  localparam logic [3:0] S_ADD_REQ  = 4'd6;
  localparam logic [3:0] S_ADD_WAIT = 4'd7;
  localparam logic [3:0] S_WRITE    = 4'd8;
  localparam logic [3:0] S_FIN      = 4'd9;

  // True when idx is the last valid index of a dimension of size dim.
  function automatic logic is_last(input logic [IW-1:0] idx, input logic [DW-1:0] dim);
    return (DW'(idx) == (dim - DW'(1'b1)));
  endfunction

  // True when a dimension is zero or exceeds its maximum.
  function automatic logic dim_bad(input logic [DW-1:0] dim, input int max_dim);
    return (dim == {DW{1'b0}}) || (dim > DW'(max_dim));
  endfunction

  // control / datapath state
  logic [3:0]    state_r,  state_s;
  logic [RW-1:0] src_a_r,  src_a_s;
  logic [RW-1:0] src_b_r,  src_b_s;
  logic [RW-1:0] dst_r,    dst_s;
  logic [DW-1:0] dim_m_r,  dim_m_s;
  logic [DW-1:0] dim_k_r,  dim_k_s;
  logic [DW-1:0] dim_n_r,  dim_n_s;
  logic [IW-1:0] i_r,      i_s;
  logic [IW-1:0] j_r,      j_s;
  logic [IW-1:0] kk_r,     kk_s;
  logic [FP-1:0] acc_r,    acc_s;
  logic [FP-1:0] prod_r,   prod_s;
  logic [FP-1:0] op_a_r,   op_a_s;
  logic [FP-1:0] op_b_r,   op_b_s;
  logic          bad_r,    bad_s;

  // registered outputs
  logic          busy_r,     busy_s;
  logic          done_r,     done_s;
  logic          error_r,    error_s;
  logic          rd_en_r,    rd_en_s;
  logic [RW-1:0] rd_a_reg_r, rd_a_reg_s;
  logic [RW-1:0] rd_b_reg_r, rd_b_reg_s;
  logic [IW-1:0] rd_a_row_r, rd_a_row_s;
  logic [IW-1:0] rd_a_col_r, rd_a_col_s;
  logic [IW-1:0] rd_b_row_r, rd_b_row_s;
  logic [IW-1:0] rd_b_col_r, rd_b_col_s;
  logic          fpu_req_r,  fpu_req_s;
  logic [1:0]    fpu_op_r,   fpu_op_s;
  logic [FP-1:0] fpu_a_r,    fpu_a_s;
  logic [FP-1:0] fpu_b_r,    fpu_b_s;
  logic          wr_en_r,    wr_en_s;
  logic [RW-1:0] wr_reg_r,   wr_reg_s;
  logic [IW-1:0] wr_row_r,   wr_row_s;
  logic [IW-1:0] wr_col_r,   wr_col_s;
  logic [FP-1:0] wr_data_r,  wr_data_s;

  // Next-state, datapath and next-output logic; outputs are a function of the
  // next state so that they appear registered and aligned with the state.
  always_comb begin
    state_s = state_r;
    src_a_s = src_a_r;
    src_b_s = src_b_r;
    dst_s   = dst_r;
    dim_m_s = dim_m_r;
    dim_k_s = dim_k_r;
    dim_n_s = dim_n_r;
    i_s     = i_r;
    j_s     = j_r;
    kk_s    = kk_r;
    acc_s   = acc_r;
    prod_s  = prod_r;
    op_a_s  = op_a_r;
    op_b_s  = op_b_r;
    bad_s   = bad_r;

    case (state_r)
      S_IDLE: begin
        if (start) begin
          src_a_s = src_a;
          src_b_s = src_b;
          dst_s   = dst;
          dim_m_s = dim_m;
          dim_k_s = dim_k;
          dim_n_s = dim_n;
          bad_s   = 1'b0;
          state_s = S_CHECK;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CHECK: begin
        if (dim_bad(dim_m_r, M) || dim_bad(dim_k_r, K) || dim_bad(dim_n_r, N)) begin
          bad_s   = 1'b1;
          state_s = S_FIN;
        end else begin
          i_s     = {IW{1'b0}};
          j_s     = {IW{1'b0}};
          kk_s    = {IW{1'b0}};
          acc_s   = {FP{1'b0}};
          state_s = S_READ;
        end
      end
      S_READ: begin
        state_s = S_RDWAIT;
      end
      S_RDWAIT: begin
        // read data is valid in this cycle (1-cycle latency after rd_en)
        op_a_s  = rd_a_data;
        op_b_s  = rd_b_data;
        state_s = S_MUL_REQ;
      end
      S_MUL_REQ: begin
        if (fpu_ack) begin
          state_s = S_MUL_WAIT;
        end else begin
          state_s = S_MUL_REQ;
        end
      end
      S_MUL_WAIT: begin
        if (fpu_result_valid) begin
          prod_s = fpu_result;
`ifdef MPU_SEQ_FUSED_FIRST_EN
          if (kk_r == {IW{1'b0}}) begin
            acc_s = fpu_result;
            if (is_last(kk_r, dim_k_r)) begin
              state_s = S_WRITE;
            end else begin
              kk_s    = kk_r + IW'(1'b1);
              state_s = S_READ;
            end
          end else begin
            state_s = S_ADD_REQ;
          end
`else
          state_s = S_ADD_REQ;
`endif
        end else begin
          state_s = S_MUL_WAIT;
        end
      end
      S_ADD_REQ: begin
        if (fpu_ack) begin
          state_s = S_ADD_WAIT;
        end else begin
          state_s = S_ADD_REQ;
        end
      end
      S_ADD_WAIT: begin
        if (fpu_result_valid) begin
          acc_s = fpu_result;
          if (is_last(kk_r, dim_k_r)) begin
            state_s = S_WRITE;
          end else begin
            kk_s    = kk_r + IW'(1'b1);
            state_s = S_READ;
          end
        end else begin
          state_s = S_ADD_WAIT;
        end
      end
      S_WRITE: begin
        // the write happens during this cycle; set up the next element
        acc_s = {FP{1'b0}};
        kk_s  = {IW{1'b0}};
        if (is_last(j_r, dim_n_r)) begin
          j_s = {IW{1'b0}};
          if (is_last(i_r, dim_m_r)) begin
            state_s = S_FIN;
          end else begin
            i_s     = i_r + IW'(1'b1);
            state_s = S_READ;
          end
        end else begin
          j_s     = j_r + IW'(1'b1);
          state_s = S_READ;
        end
      end
      S_FIN: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    busy_s  = (state_s != S_IDLE);
    done_s  = (state_s == S_FIN);
    error_s = (state_s == S_FIN) ? bad_s : 1'b0;

    if (state_s == S_READ) begin
      rd_en_s    = 1'b1;
      rd_a_reg_s = src_a_s;
      rd_a_row_s = i_s;
      rd_a_col_s = kk_s;
      rd_b_reg_s = src_b_s;
      rd_b_row_s = kk_s;
      rd_b_col_s = j_s;
    end else begin
      rd_en_s    = 1'b0;
      rd_a_reg_s = {RW{1'b0}};
      rd_a_row_s = {IW{1'b0}};
      rd_a_col_s = {IW{1'b0}};
      rd_b_reg_s = {RW{1'b0}};
      rd_b_row_s = {IW{1'b0}};
      rd_b_col_s = {IW{1'b0}};
    end

    case (state_s)
      S_MUL_REQ: begin
        fpu_req_s = 1'b1;
        fpu_op_s  = FPU_MULT;
        fpu_a_s   = op_a_s;
        fpu_b_s   = op_b_s;
      end
      S_ADD_REQ: begin
        fpu_req_s = 1'b1;
        fpu_op_s  = FPU_ADD;
        fpu_a_s   = acc_s;
        fpu_b_s   = prod_s;
      end
      default: begin
        fpu_req_s = 1'b0;
        fpu_op_s  = FPU_NOP;
        fpu_a_s   = {FP{1'b0}};
        fpu_b_s   = {FP{1'b0}};
      end
    endcase

    if (state_s == S_WRITE) begin
      wr_en_s   = 1'b1;
      wr_reg_s  = dst_s;
      wr_row_s  = i_s;
      wr_col_s  = j_s;
      wr_data_s = acc_s;
    end else begin
      wr_en_s   = 1'b0;
      wr_reg_s  = {RW{1'b0}};
      wr_row_s  = {IW{1'b0}};
      wr_col_s  = {IW{1'b0}};
      wr_data_s = {FP{1'b0}};
    end
  end

  // FSM state, latched command and dot-product datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      src_a_r <= {RW{1'b0}};
      src_b_r <= {RW{1'b0}};
      dst_r   <= {RW{1'b0}};
      dim_m_r <= {DW{1'b0}};
      dim_k_r <= {DW{1'b0}};
      dim_n_r <= {DW{1'b0}};
      i_r     <= {IW{1'b0}};
      j_r     <= {IW{1'b0}};
      kk_r    <= {IW{1'b0}};
      acc_r   <= {FP{1'b0}};
      prod_r  <= {FP{1'b0}};
      op_a_r  <= {FP{1'b0}};
      op_b_r  <= {FP{1'b0}};
      bad_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      src_a_r <= src_a_s;
      src_b_r <= src_b_s;
      dst_r   <= dst_s;
      dim_m_r <= dim_m_s;
      dim_k_r <= dim_k_s;
      dim_n_r <= dim_n_s;
      i_r     <= i_s;
      j_r     <= j_s;
      kk_r    <= kk_s;
      acc_r   <= acc_s;
      prod_r  <= prod_s;
      op_a_r  <= op_a_s;
      op_b_r  <= op_b_s;
      bad_r   <= bad_s;
    end
  end

  // Output registers; reset forces every output (and fpu_op = NOP) to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      rd_en_r    <= 1'b0;
      rd_a_reg_r <= {RW{1'b0}};
      rd_b_reg_r <= {RW{1'b0}};
      rd_a_row_r <= {IW{1'b0}};
      rd_a_col_r <= {IW{1'b0}};
      rd_b_row_r <= {IW{1'b0}};
      rd_b_col_r <= {IW{1'b0}};
      fpu_req_r  <= 1'b0;
      fpu_op_r   <= FPU_NOP;
      fpu_a_r    <= {FP{1'b0}};
      fpu_b_r    <= {FP{1'b0}};
      wr_en_r    <= 1'b0;
      wr_reg_r   <= {RW{1'b0}};
      wr_row_r   <= {IW{1'b0}};
      wr_col_r   <= {IW{1'b0}};
      wr_data_r  <= {FP{1'b0}};
    end else begin
      busy_r     <= busy_s;
      done_r     <= done_s;
      error_r    <= error_s;
      rd_en_r    <= rd_en_s;
      rd_a_reg_r <= rd_a_reg_s;
      rd_b_reg_r <= rd_b_reg_s;
      rd_a_row_r <= rd_a_row_s;
      rd_a_col_r <= rd_a_col_s;
      rd_b_row_r <= rd_b_row_s;
      rd_b_col_r <= rd_b_col_s;
      fpu_req_r  <= fpu_req_s;
      fpu_op_r   <= fpu_op_s;
      fpu_a_r    <= fpu_a_s;
      fpu_b_r    <= fpu_b_s;
      wr_en_r    <= wr_en_s;
      wr_reg_r   <= wr_reg_s;
      wr_row_r   <= wr_row_s;
      wr_col_r   <= wr_col_s;
      wr_data_r  <= wr_data_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign error    = error_r;
  assign rd_en    = rd_en_r;
  assign rd_a_reg = rd_a_reg_r;
  assign rd_b_reg = rd_b_reg_r;
  assign rd_a_row = rd_a_row_r;
  assign rd_a_col = rd_a_col_r;
  assign rd_b_row = rd_b_row_r;
  assign rd_b_col = rd_b_col_r;
  assign fpu_req  = fpu_req_r;
  assign fpu_op   = fpu_op_r;
  assign fpu_a    = fpu_a_r;
  assign fpu_b    = fpu_b_r;
  assign wr_en    = wr_en_r;
  assign wr_reg   = wr_reg_r;
  assign wr_row   = wr_row_r;
  assign wr_col   = wr_col_r;
  assign wr_data  = wr_data_r;

endmodule
